pipe_hazard_ctrl: RTL and testbench

//  Drives the load/flush inputs of the four LC-3b pipeline registers (IF/ID, ID/EX, EX/ME, ME/WB) and the PC.

---
 rtl/lc3b_types.sv | 15 +
 rtl/pipe_hazard_detect.sv | 29 ++
 rtl/pipe_hazard_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b type definitions.
//   lc3b_reg          - 3-bit architectural register index (R0..R7)
//   pipe_ctrl_state_t - pipeline control FSM state (RUN, DSTALL, REDIR)
// No ports; imported with "import lc3b_types::*".
package lc3b_types;

  typedef logic [2:0] lc3b_reg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DSTALL = 2'd1,
    REDIR  = 2'd2
  } pipe_ctrl_state_t;

endpackage : lc3b_types

// File: rtl/pipe_hazard_detect.sv
// pipe_hazard_detect: combinational load-use hazard comparator.
// A load sitting in ID/EX whose destination is read by the instruction
// in IF/ID cannot forward in time, so the consumer must wait one cycle.
// Ports:
//   idex_mem_read  in  ID/EX instruction is a load
//   idex_dest      in  ID/EX destination register
//   ifid_src1/2    in  IF/ID source registers
//   ifid_use_src1/2 in IF/ID instruction actually reads src1/src2
//   lu_hazard      out load-use hazard present this cycle
module pipe_hazard_detect
  import lc3b_types::*;
(
  input  logic    idex_mem_read,
  input  lc3b_reg idex_dest,
  input  lc3b_reg ifid_src1,
  input  lc3b_reg ifid_src2,
  input  logic    ifid_use_src1,
  input  logic    ifid_use_src2,
  output logic    lu_hazard
);

  logic match1_s;
  logic match2_s;

  assign match1_s  = ifid_use_src1 & (ifid_src1 == idex_dest);
  assign match2_s  = ifid_use_src2 & (ifid_src2 == idex_dest);
  assign lu_hazard = idex_mem_read & (match1_s | match2_s);

endmodule : pipe_hazard_detect

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load/flush control for the four LC-3b pipeline
// registers (IF/ID, ID/EX, EX/ME, ME/WB) and the PC.
// Priority (highest first): data-miss freeze, redirect (or a redirect
// deferred across a freeze), load-use stall, instruction-miss bubble, run.
// While reset_n is low every pipe register loads a NOP so the pipeline
// (which has no reset of its own) starts clean.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   imem_resp             instruction fetch completes this cycle
//   dmem_req, dmem_resp   data access requested by EX/ME / completes
//   idex_mem_read, idex_dest, ifid_src1/2, ifid_use_src1/2  hazard inputs
//   redirect              taken branch/JMP/JSR/TRAP resolved in EX/ME
//   load_pc, pc_redirect  PC enable and target-path select
//   load_ifid/idex/exme/mewb    pipe register load enables
//   bubble_ifid/idex/exme       load a NOP instead of stage data
//   perf_stall_cyc, perf_flush_cnt  saturating performance counters
// Configuration: define PIPE_PERF_CNT_EN to build the performance
// counters; otherwise both perf outputs are tied to zero.
module pipe_hazard_ctrl
  import lc3b_types::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             imem_resp,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  input  logic             idex_mem_read,
  input  lc3b_reg          idex_dest,
  input  lc3b_reg          ifid_src1,
  input  lc3b_reg          ifid_src2,
  input  logic             ifid_use_src1,
  input  logic             ifid_use_src2,
  input  logic             redirect,
  output logic             load_pc,
  output logic             pc_redirect,
  output logic             load_ifid,
  output logic             load_idex,
  output logic             load_exme,
  output logic             load_mewb,
  output logic             bubble_ifid,
  output logic             bubble_idex,
  output logic             bubble_exme,
  output logic [CNT_W-1:0] perf_stall_cyc,
  output logic [CNT_W-1:0] perf_flush_cnt
);

  pipe_ctrl_state_t state_q, state_d;
  logic             redir_pend_q, redir_pend_d;

  logic dmiss_s;
  logic imiss_s;
  logic lu_hazard_s;
  logic redir_take_s;

  // Control values before the reset override is applied
  logic c_load_pc_s, c_pc_redirect_s;
  logic c_load_ifid_s, c_load_idex_s, c_load_exme_s, c_load_mewb_s;
  logic c_bubble_ifid_s, c_bubble_idex_s, c_bubble_exme_s;

  pipe_hazard_detect u_detect (
    .idex_mem_read (idex_mem_read),
    .idex_dest     (idex_dest),
    .ifid_src1     (ifid_src1),
    .ifid_src2     (ifid_src2),
    .ifid_use_src1 (ifid_use_src1),
    .ifid_use_src2 (ifid_use_src2),
    .lu_hazard     (lu_hazard_s)
  );

  assign dmiss_s = dmem_req & ~dmem_resp;
  assign imiss_s = ~imem_resp;
  // A redirect is applied only when the pipe is not frozen; a deferred
  // one is replayed from the REDIR state.
  assign redir_take_s = ~dmiss_s & (redirect | (state_q == REDIR));

  // Next-state and per-stage control by priority
  always_comb begin
    state_d         = state_q;
    redir_pend_d    = redir_pend_q;
    c_load_pc_s     = 1'b1;
    c_pc_redirect_s = 1'b0;
    c_load_ifid_s   = 1'b1;
    c_load_idex_s   = 1'b1;
    c_load_exme_s   = 1'b1;
    c_load_mewb_s   = 1'b1;
    c_bubble_ifid_s = 1'b0;
    c_bubble_idex_s = 1'b0;
    c_bubble_exme_s = 1'b0;

    if (dmiss_s) begin
      // Full freeze; a redirect seen now is remembered until applied
      c_load_pc_s   = 1'b0;
      c_load_ifid_s = 1'b0;
      c_load_idex_s = 1'b0;
      c_load_exme_s = 1'b0;
      c_load_mewb_s = 1'b0;
      state_d       = DSTALL;
      if (redirect) begin
        redir_pend_d = 1'b1;
      end else begin
        redir_pend_d = redir_pend_q;
      end
    end else if (redir_take_s) begin
      // Squash the three younger stages; they need no hazard stall
      c_pc_redirect_s = 1'b1;
      c_bubble_ifid_s = 1'b1;
      c_bubble_idex_s = 1'b1;
      c_bubble_exme_s = 1'b1;
      redir_pend_d    = 1'b0;
      state_d         = RUN;
    end else begin
      // The data-response cycle is a normal cycle; a deferred redirect
      // is applied in the following one.
      case (state_q)
        DSTALL:  state_d = redir_pend_q ? REDIR : RUN;
        default: state_d = RUN;
      endcase

      if (lu_hazard_s) begin
        c_load_pc_s     = 1'b0;
        c_load_ifid_s   = 1'b0;
        c_bubble_idex_s = 1'b1;
      end else if (imiss_s) begin
        c_load_pc_s     = 1'b0;
        c_bubble_ifid_s = 1'b1;
      end else begin
        c_load_pc_s     = 1'b1;
      end
    end
  end

  // Reset override: fill every stage with NOPs and hold the PC
  always_comb begin
    if (!reset_n) begin
      load_pc     = 1'b0;
      pc_redirect = 1'b0;
      load_ifid   = 1'b1;
      load_idex   = 1'b1;
      load_exme   = 1'b1;
      load_mewb   = 1'b1;
      bubble_ifid = 1'b1;
      bubble_idex = 1'b1;
      bubble_exme = 1'b1;
    end else begin
      load_pc     = c_load_pc_s;
      pc_redirect = c_pc_redirect_s;
      load_ifid   = c_load_ifid_s;
      load_idex   = c_load_idex_s;
      load_exme   = c_load_exme_s;
      load_mewb   = c_load_mewb_s;
      bubble_ifid = c_bubble_ifid_s;
      bubble_idex = c_bubble_idex_s;
      bubble_exme = c_bubble_exme_s;
    end
  end

  // Control FSM state and deferred-redirect flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= RUN;
      redir_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      redir_pend_q <= redir_pend_d;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic             stall_evt_s;
  logic             flush_evt_s;
  logic [CNT_W-1:0] stall_cyc_q, stall_cyc_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  assign stall_evt_s = dmiss_s | (~redir_take_s & (lu_hazard_s | imiss_s));
  assign flush_evt_s = redir_take_s;

  // Saturating increments of the performance counters
  always_comb begin
    stall_cyc_d = stall_cyc_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_evt_s && (stall_cyc_q != {CNT_W{1'b1}})) begin
      stall_cyc_d = stall_cyc_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cyc_d = stall_cyc_q;
    end
    if (flush_evt_s && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Performance counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cyc_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
    end else begin
      stall_cyc_q <= stall_cyc_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cyc = stall_cyc_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  assign perf_stall_cyc = {CNT_W{1'b0}};
  assign perf_flush_cnt = {CNT_W{1'b0}};
`endif

endmodule : pipe_hazard_ctrl

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed self-checking bench for pipe_hazard_ctrl.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// Control outputs are compared as one 9-bit word:
//   {load_pc, pc_redirect, load_ifid, load_idex, load_exme, load_mewb,
//    bubble_ifid, bubble_idex, bubble_exme}
module tb_pipe_hazard_ctrl;
  import lc3b_types::*;

  localparam logic [8:0] C_RST   = 9'b0_0_1111_111;
  localparam logic [8:0] C_NORM  = 9'b1_0_1111_000;
  localparam logic [8:0] C_LU    = 9'b0_0_0111_010;
  localparam logic [8:0] C_IMISS = 9'b0_0_1111_100;
  localparam logic [8:0] C_FRZ   = 9'b0_0_0000_000;
  localparam logic [8:0] C_REDIR = 9'b1_1_1111_111;

`ifdef PIPE_PERF_CNT_EN
  localparam logic [31:0] EXP_STALL = 32'd10;
  localparam logic [31:0] EXP_FLUSH = 32'd2;
`else
  localparam logic [31:0] EXP_STALL = 32'd0;
  localparam logic [31:0] EXP_FLUSH = 32'd0;
`endif

  logic        clk;
  logic        reset_n;
  logic        imem_resp, dmem_req, dmem_resp, idex_mem_read;
  lc3b_reg     idex_dest, ifid_src1, ifid_src2;
  logic        ifid_use_src1, ifid_use_src2, redirect;
  logic        load_pc, pc_redirect, load_ifid, load_idex, load_exme, load_mewb;
  logic        bubble_ifid, bubble_idex, bubble_exme;
  logic [31:0] perf_stall_cyc, perf_flush_cnt;
  logic [8:0]  ctrl;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_hazard_ctrl #(.CNT_W(32)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_resp      (imem_resp),
    .dmem_req       (dmem_req),
    .dmem_resp      (dmem_resp),
    .idex_mem_read  (idex_mem_read),
    .idex_dest      (idex_dest),
    .ifid_src1      (ifid_src1),
    .ifid_src2      (ifid_src2),
    .ifid_use_src1  (ifid_use_src1),
    .ifid_use_src2  (ifid_use_src2),
    .redirect       (redirect),
    .load_pc        (load_pc),
    .pc_redirect    (pc_redirect),
    .load_ifid      (load_ifid),
    .load_idex      (load_idex),
    .load_exme      (load_exme),
    .load_mewb      (load_mewb),
    .bubble_ifid    (bubble_ifid),
    .bubble_idex    (bubble_idex),
    .bubble_exme    (bubble_exme),
    .perf_stall_cyc (perf_stall_cyc),
    .perf_flush_cnt (perf_flush_cnt)
  );

  assign ctrl = {load_pc, pc_redirect, load_ifid, load_idex, load_exme, load_mewb,
                 bubble_ifid, bubble_idex, bubble_exme};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_ctrl(input string tag, input logic [8:0] exp);
    check_eq(tag, {23'd0, ctrl}, {23'd0, exp});
  endtask

  task automatic chk_state(input string tag, input pipe_ctrl_state_t exp);
    check_eq(tag, {30'd0, dut.state_q}, {30'd0, exp});
  endtask

  task automatic idle();
    imem_resp     = 1'b1;
    dmem_req      = 1'b0;
    dmem_resp     = 1'b0;
    idex_mem_read = 1'b0;
    idex_dest     = 3'd0;
    ifid_src1     = 3'd0;
    ifid_src2     = 3'd0;
    ifid_use_src1 = 1'b0;
    ifid_use_src2 = 1'b0;
    redirect      = 1'b0;
  endtask

  // Data miss: request outstanding, no response
  task automatic dmiss_cycle(input logic redir);
    @(negedge clk);
    idle();
    dmem_req = 1'b1;
    redirect = redir;
    #1;
  endtask

  initial begin
    idle();
    reset_n = 1'b0;

    // Reset: pipes fill with NOPs, PC held, counters clear
    repeat (2) @(negedge clk);
    #1;
    chk_ctrl("reset_ctrl", C_RST);
    chk_state("reset_state", RUN);
    check_eq("reset_perf_stall", perf_stall_cyc, 32'd0);
    check_eq("reset_perf_flush", perf_flush_cnt, 32'd0);
    imem_resp = 1'b0;
    redirect  = 1'b1;
    #1;
    chk_ctrl("reset_overrides_inputs", C_RST);
    idle();

    // First cycles after reset run normally
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk_ctrl("first_cycle", C_NORM);
    @(negedge clk); #1;
    chk_ctrl("second_cycle", C_NORM);
    chk_state("run_state", RUN);

    // Load-use through src1: exactly one stall cycle
    @(negedge clk);
    idle();
    idex_mem_read = 1'b1; idex_dest = 3'd3; ifid_src1 = 3'd3; ifid_use_src1 = 1'b1;
    #1;
    chk_ctrl("lu_src1", C_LU);
    @(negedge clk); idle(); #1;
    chk_ctrl("lu_src1_done", C_NORM);

    // Matching register that is not read, and a non-load match: no hazard
    @(negedge clk);
    idle();
    idex_mem_read = 1'b1; idex_dest = 3'd3; ifid_src1 = 3'd3; ifid_src2 = 3'd5; ifid_use_src2 = 1'b1;
    #1;
    chk_ctrl("no_lu_unused_src", C_NORM);
    @(negedge clk);
    idle();
    idex_dest = 3'd4; ifid_src1 = 3'd4; ifid_use_src1 = 1'b1;
    #1;
    chk_ctrl("no_lu_not_load", C_NORM);

    // Load-use through src2
    @(negedge clk);
    idle();
    idex_mem_read = 1'b1; idex_dest = 3'd6; ifid_src2 = 3'd6; ifid_use_src2 = 1'b1;
    #1;
    chk_ctrl("lu_src2", C_LU);

    // Instruction miss
    @(negedge clk); idle(); imem_resp = 1'b0; #1;
    chk_ctrl("imiss", C_IMISS);

    // Four-cycle data miss freeze, then resume on response
    dmiss_cycle(1'b0); chk_ctrl("dmiss4_c1", C_FRZ);
    dmiss_cycle(1'b0); chk_ctrl("dmiss4_c2", C_FRZ); chk_state("dmiss4_state", DSTALL);
    dmiss_cycle(1'b0); chk_ctrl("dmiss4_c3", C_FRZ);
    dmiss_cycle(1'b0); chk_ctrl("dmiss4_c4", C_FRZ);
    @(negedge clk); idle(); dmem_req = 1'b1; dmem_resp = 1'b1; #1;
    chk_ctrl("dmiss4_resp", C_NORM);
    @(negedge clk); idle(); #1;
    chk_state("dmiss4_after", RUN);
    chk_ctrl("dmiss4_after_ctrl", C_NORM);

    // Three-cycle miss with a redirect in the 2nd: deferred until after resp
    dmiss_cycle(1'b0); chk_ctrl("dmiss3_c1", C_FRZ);
    dmiss_cycle(1'b1); chk_ctrl("dmiss3_c2_redir", C_FRZ);
    dmiss_cycle(1'b0); chk_ctrl("dmiss3_c3", C_FRZ);
    check_eq("dmiss3_pend", {31'd0, dut.redir_pend_q}, 32'd1);
    @(negedge clk); idle(); dmem_req = 1'b1; dmem_resp = 1'b1; #1;
    chk_ctrl("dmiss3_resp", C_NORM);
    @(negedge clk); idle(); #1;
    chk_state("dmiss3_redir_state", REDIR);
    chk_ctrl("dmiss3_redir_ctrl", C_REDIR);
    @(negedge clk); idle(); #1;
    chk_ctrl("dmiss3_done", C_NORM);
    check_eq("dmiss3_pend_clr", {31'd0, dut.redir_pend_q}, 32'd0);

    // Redirect wins over a load-use hazard and an instruction miss
    @(negedge clk);
    idle();
    redirect = 1'b1; imem_resp = 1'b0;
    idex_mem_read = 1'b1; idex_dest = 3'd2; ifid_src1 = 3'd2; ifid_use_src1 = 1'b1;
    #1;
    chk_ctrl("redir_over_hazards", C_REDIR);
    @(negedge clk); idle(); #1;
    chk_ctrl("redir_no_stall", C_NORM);

    // Instruction and data responses together: no stall
    @(negedge clk); idle(); dmem_req = 1'b1; dmem_resp = 1'b1; #1;
    chk_ctrl("both_resp", C_NORM);
    check_eq("perf_stall", perf_stall_cyc, EXP_STALL);
    check_eq("perf_flush", perf_flush_cnt, EXP_FLUSH);

    // Reset in the middle of a stall with a pending redirect
    dmiss_cycle(1'b1);
    dmiss_cycle(1'b0);
    chk_ctrl("pre_reset_frz", C_FRZ);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk_ctrl("mid_reset_ctrl", C_RST);
    chk_state("mid_reset_state", RUN);
    check_eq("mid_reset_pend", {31'd0, dut.redir_pend_q}, 32'd0);
    check_eq("mid_reset_perf", perf_stall_cyc, 32'd0);
    @(negedge clk);
    idle();
    reset_n = 1'b1;
    #1;
    chk_ctrl("post_reset", C_NORM);
    @(negedge clk); #1;
    chk_state("post_reset_no_redir", RUN);
    chk_ctrl("post_reset_ctrl", C_NORM);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_pipe_hazard_ctrl
